lc2k_mc_ctrl: RTL

Multi-cycle control FSM for the LC2K processor. It consumes the 3-bit opcode from the instruction decoder plus datapath status, and sequences the shared datapath: PC, IR, register file, ALU and a single unified memory port. It owns the fetch/decode/execute/memory/writeback schedule and the memory request handshake, and it signals halt.

---
 rtl/lc2k_mc_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/lc2k_mc_ctrl.sv
// Multi-cycle control FSM for LC2K: sequences fetch/decode/exec/mem/wb over a shared datapath.
// Optional perf counters (cycle_count, instr_count) are built when LC2K_PERF_CNT_EN is defined.
module lc2k_mc_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] opcode,
   input  logic       alu_zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       mem_addr_sel,
   output logic       ir_we,
   output logic       mdr_we,
   output logic       ab_we,
   output logic       aluout_we,
   output logic       alu_op,
   output logic       alu_srcb_sel,
   output logic       pc_we,
   output logic [1:0] pc_sel,
   output logic       reg_we,
   output logic       reg_waddr_sel,
   output logic [1:0] reg_wdata_sel,
   output logic       halted
`ifdef LC2K_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] instr_count
`endif
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
   } state_t;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_NOR  = 3'd1;
   localparam logic [2:0] OP_LW   = 3'd2;
   localparam logic [2:0] OP_SW   = 3'd3;
   localparam logic [2:0] OP_BEQ  = 3'd4;
   localparam logic [2:0] OP_JALR = 3'd5;
   localparam logic [2:0] OP_HALT = 3'd6;

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
   end

   state_t state_q, state_d;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr_sel  = 1'b0;
      ir_we         = 1'b0;
      mdr_we        = 1'b0;
      ab_we         = 1'b0;
      aluout_we     = 1'b0;
      alu_op        = 1'b0;
      alu_srcb_sel  = 1'b0;
      pc_we         = 1'b0;
      pc_sel        = 2'd0;
      reg_we        = 1'b0;
      reg_waddr_sel = 1'b0;
      reg_wdata_sel = 2'd0;
      halted        = 1'b0;
      // Reset masks every strobe, including a mem_ready landing in the same cycle.
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  ir_we   = 1'b1;
                  state_d = S_DECODE;
               end
            end
            S_DECODE: begin
               pc_we   = 1'b1;
               ab_we   = 1'b1;
               state_d = S_EXEC;
            end
            S_EXEC: begin
               case (opcode)
                  OP_ADD, OP_NOR: begin
                     alu_op    = opcode[0];
                     aluout_we = 1'b1;
                     state_d   = S_WB;
                  end
                  OP_LW, OP_SW: begin
                     alu_srcb_sel = 1'b1;
                     aluout_we    = 1'b1;
                     state_d      = S_MEM;
                  end
                  OP_BEQ: begin
                     pc_we   = alu_zero;
                     pc_sel  = alu_zero ? 2'd1 : 2'd0;
                     state_d = S_FETCH;
                  end
                  OP_JALR: begin
                     reg_we        = 1'b1;
                     reg_waddr_sel = 1'b1;
                     reg_wdata_sel = 2'd2;
                     pc_we         = 1'b1;
                     pc_sel        = 2'd2;
                     state_d       = S_FETCH;
                  end
                  OP_HALT: state_d = S_HALTED;
                  default: state_d = S_FETCH;
               endcase
            end
            S_MEM: begin
               mem_req      = 1'b1;
               mem_addr_sel = 1'b1;
               mem_we       = (opcode == OP_SW);
               if (mem_ready) begin
                  mdr_we  = (opcode == OP_LW);
                  state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
               end
            end
            S_WB: begin
               reg_we        = 1'b1;
               reg_waddr_sel = (opcode == OP_LW);
               reg_wdata_sel = (opcode == OP_LW) ? 2'd1 : 2'd0;
               state_d       = S_FETCH;
            end
            S_HALTED: halted = 1'b1;
            default:  state_d = S_FETCH;
         endcase
      end
   end

`ifdef LC2K_PERF_CNT_EN
   logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
   logic [CNT_W-1:0] instr_count_q, instr_count_d;
   logic             retire;

   // An instruction retires on the cycle that hands control back to FETCH, or enters HALTED.
   assign retire = (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) &&
                   (state_d == S_FETCH || state_d == S_HALTED);

   always_comb begin
      cycle_count_d = cycle_count_q;
      instr_count_d = instr_count_q;
      if (state_q != S_HALTED) cycle_count_d = cycle_count_q + 1'b1;
      if (retire)              instr_count_d = instr_count_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_count_q <= '0;
         instr_count_q <= '0;
      end else begin
         cycle_count_q <= cycle_count_d;
         instr_count_q <= instr_count_d;
      end
   end

   assign cycle_count = cycle_count_q;
   assign instr_count = instr_count_q;
`endif

endmodule
